// File: rtl/router_pkg.sv
// Shared router definitions: port enumeration, flit field offsets and XY route.
package router_pkg;

  typedef enum logic [2:0] {
    NORTH = 3'd0,
    SOUTH = 3'd1,
    EAST  = 3'd2,
    WEST  = 3'd3,
    LOCAL = 3'd4
  } port_e;

  localparam int NUM_PORTS = 5;

  // Field positions counted down from the flit MSB; dest {row,col} starts below priority.
  localparam int HEAD_OFS = 1;
  localparam int TAIL_OFS = 2;
  localparam int PRIO_OFS = 3;
  localparam int DEST_OFS = 3;

  function automatic port_e xy_route(input logic [7:0] cur_row, input logic [7:0] cur_col,
                                     input logic [7:0] dst_row, input logic [7:0] dst_col);
    if (dst_col > cur_col)      return EAST;
    else if (dst_col < cur_col) return WEST;
    else if (dst_row > cur_row) return SOUTH;
    else if (dst_row < cur_row) return NORTH;
    else                        return LOCAL;
  endfunction

endpackage

// File: rtl/vc_fifo.sv
// Per-(input, VC) flit buffer; push while full and pop while empty are ignored.
module vc_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (do_pop)
        rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/vc_credit_router.sv
// 5-port credit-based VC wormhole router with XY routing and two-stage round-robin.
// ROUTER_PRIORITY_EN: when defined, priority-flagged packets win both arbitration stages.
module vc_credit_router
  import router_pkg::*;
#(
  parameter int ROUTER_ID    = 0,
  parameter int ROUTER_COLS  = 4,
  parameter int FLIT_W       = 64,
  parameter int NUM_VCS      = 2,
  parameter int BUFFER_DEPTH = 4,
  parameter int COORD_W      = 3,
  localparam int VC_W        = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_PORTS-1:0]          in_valid,
  input  logic [NUM_PORTS*FLIT_W-1:0]   in_flit,
  input  logic [NUM_PORTS*VC_W-1:0]     in_vc,
  output logic [NUM_PORTS*NUM_VCS-1:0]  credit_out,
  output logic [NUM_PORTS-1:0]          out_valid,
  output logic [NUM_PORTS*FLIT_W-1:0]   out_flit,
  output logic [NUM_PORTS*VC_W-1:0]     out_vc,
  input  logic [NUM_PORTS*NUM_VCS-1:0]  credit_in,
  output logic                          err_overflow
);

  localparam int P   = NUM_PORTS;
  localparam int NV  = NUM_VCS;
  localparam int NQ  = P * NV;
  localparam int CRW = $clog2(BUFFER_DEPTH + 1);

  localparam logic [7:0] MY_ROW = 8'(ROUTER_ID / ROUTER_COLS);
  localparam logic [7:0] MY_COL = 8'(ROUTER_ID % ROUTER_COLS);

  localparam int B_HEAD = FLIT_W - HEAD_OFS;
  localparam int B_TAIL = FLIT_W - TAIL_OFS;
  localparam int B_PRIO = FLIT_W - PRIO_OFS;
  localparam int B_ROW  = FLIT_W - 1 - DEST_OFS;
  localparam int B_COL  = B_ROW - COORD_W;

  logic [NQ-1:0]     push, pop, q_full, q_empty;
  logic [FLIT_W-1:0] q_head [NQ];
  logic [P-1:0]      drop;

  logic [NQ-1:0]     ready, cand_head, cand_tail, cand_prio, sent;
  logic [2:0]        cand_route [NQ];

  logic [2:0]        route_q [NQ];
  logic [NQ-1:0]     prio_q;
  logic [NQ-1:0]     lock_vld;
  logic [2:0]        lock_in [NQ];
  logic [CRW-1:0]    credit [NQ];
  logic [VC_W-1:0]   in_ptr [P];
  logic [2:0]        out_ptr [P];

  logic [P-1:0]      sel_ok;
  int                sel_vc [P];
  int                sel_q [P];
  logic [P-1:0]      grant_ok;
  int                grant_in [P];
  int                grant_vc [P];
  int                grant_q [P];

  for (genvar g = 0; g < NQ; g++) begin : g_fifo
    vc_fifo #(.WIDTH(FLIT_W), .DEPTH(BUFFER_DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push[g]),
      .din   (in_flit[(g / NV) * FLIT_W +: FLIT_W]),
      .pop   (pop[g]),
      .dout  (q_head[g]),
      .full  (q_full[g]),
      .empty (q_empty[g])
    );
  end

  always_comb begin : write_logic
    push = '0;
    drop = '0;
    for (int i = 0; i < P; i++) begin
      for (int v = 0; v < NV; v++) begin
        if (in_valid[i] && (int'(in_vc[i*VC_W +: VC_W]) == v)) begin
          push[i*NV+v] = !q_full[i*NV+v];
          drop[i]      = drop[i] | q_full[i*NV+v];
        end
      end
    end
  end

  // Head flits route from their own dest field; body/tail reuse the route latched at head grant.
  always_comb begin : cand_logic
    int oq;
    oq = 0;
    for (int q = 0; q < NQ; q++) begin
      cand_head[q] = q_head[q][B_HEAD];
      cand_tail[q] = q_head[q][B_TAIL];
      if (cand_head[q]) begin
        cand_route[q] = 3'(xy_route(MY_ROW, MY_COL,
                                    8'(q_head[q][B_ROW -: COORD_W]),
                                    8'(q_head[q][B_COL -: COORD_W])));
        cand_prio[q]  = q_head[q][B_PRIO];
      end else begin
        cand_route[q] = route_q[q];
        cand_prio[q]  = prio_q[q];
      end
      ready[q] = 1'b0;
      if (int'(cand_route[q]) < P) begin
        oq       = int'(cand_route[q]) * NV + (q % NV);
        ready[q] = !q_empty[q] && (credit[oq] != '0) &&
                   ((cand_head[q] && !lock_vld[oq]) ||
                    (lock_vld[oq] && (int'(lock_in[oq]) == q / NV)));
      end
    end
  end

  always_comb begin : stage1
    logic any_hi;
    int   q;
    q = 0;
    for (int i = 0; i < P; i++) begin
      any_hi = 1'b0;
`ifdef ROUTER_PRIORITY_EN
      for (int v = 0; v < NV; v++)
        if (ready[i*NV+v] && cand_prio[i*NV+v]) any_hi = 1'b1;
`endif
      sel_ok[i] = 1'b0;
      sel_vc[i] = 0;
      sel_q[i]  = i * NV;
      for (int k = 0; k < NV; k++) begin
        q = i * NV + (int'(in_ptr[i]) + k) % NV;
        if (!sel_ok[i] && ready[q] && (!any_hi || cand_prio[q])) begin
          sel_ok[i] = 1'b1;
          sel_vc[i] = q % NV;
          sel_q[i]  = q;
        end
      end
    end
  end

  always_comb begin : stage2
    logic         any_hi;
    logic [P-1:0] req;
    logic [P-1:0] hi;
    int           ii;
    ii  = 0;
    pop  = '0;
    sent = '0;
    for (int o = 0; o < P; o++) begin
      req = '0;
      hi  = '0;
      for (int i = 0; i < P; i++) begin
        req[i] = sel_ok[i] && (cand_route[sel_q[i]] == 3'(o));
        hi[i]  = req[i] && cand_prio[sel_q[i]];
      end
      any_hi = 1'b0;
`ifdef ROUTER_PRIORITY_EN
      any_hi = |hi;
`endif
      grant_ok[o] = 1'b0;
      grant_in[o] = 0;
      grant_vc[o] = 0;
      grant_q[o]  = 0;
      for (int k = 0; k < P; k++) begin
        ii = (int'(out_ptr[o]) + k) % P;
        if (!grant_ok[o] && req[ii] && (!any_hi || hi[ii])) begin
          grant_ok[o] = 1'b1;
          grant_in[o] = ii;
          grant_vc[o] = sel_vc[ii];
          grant_q[o]  = sel_q[ii];
        end
      end
      if (grant_ok[o]) begin
        pop[grant_q[o]]       = 1'b1;
        sent[o*NV+grant_vc[o]] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid    <= '0;
      out_flit     <= '0;
      out_vc       <= '0;
      credit_out   <= '0;
      err_overflow <= 1'b0;
      lock_vld     <= '0;
      prio_q       <= '0;
      for (int q = 0; q < NQ; q++) begin
        route_q[q] <= '0;
        lock_in[q] <= '0;
        credit[q]  <= CRW'(BUFFER_DEPTH);
      end
      for (int p = 0; p < P; p++) begin
        in_ptr[p]  <= '0;
        out_ptr[p] <= '0;
      end
    end else begin
      out_valid    <= '0;
      credit_out   <= '0;
      err_overflow <= err_overflow | (|drop);

      for (int o = 0; o < P; o++) begin
        if (grant_ok[o]) begin
          out_valid[o]                  <= 1'b1;
          out_flit[o*FLIT_W +: FLIT_W]  <= q_head[grant_q[o]];
          out_vc[o*VC_W +: VC_W]        <= VC_W'(grant_vc[o]);
          credit_out[grant_q[o]]        <= 1'b1;
          in_ptr[grant_in[o]]           <= VC_W'((grant_vc[o] + 1) % NV);
          out_ptr[o]                    <= 3'((grant_in[o] + 1) % P);
          if (cand_head[grant_q[o]]) begin
            route_q[grant_q[o]] <= 3'(o);
            prio_q[grant_q[o]]  <= cand_prio[grant_q[o]];
          end
          // Single-flit packets (head and tail both set) never hold the output VC.
          if (cand_head[grant_q[o]] && !cand_tail[grant_q[o]]) begin
            lock_vld[o*NV+grant_vc[o]] <= 1'b1;
            lock_in[o*NV+grant_vc[o]]  <= 3'(grant_in[o]);
          end else if (!cand_head[grant_q[o]] && cand_tail[grant_q[o]]) begin
            lock_vld[o*NV+grant_vc[o]] <= 1'b0;
          end
        end
      end

      for (int q = 0; q < NQ; q++) begin
        case ({sent[q], credit_in[q]})
          2'b10:   if (credit[q] != '0) credit[q] <= credit[q] - 1'b1;
          2'b01:   if (credit[q] < CRW'(BUFFER_DEPTH)) credit[q] <= credit[q] + 1'b1;
          default: credit[q] <= credit[q];
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vc_credit_router.sv
// Directed bench for vc_credit_router at ROUTER_ID=5 in a 4-column mesh (row 1, col 1).
module tb_vc_credit_router;

  localparam int FW = 64;
  localparam int NV = 2;
  localparam int N  = 0;
  localparam int S  = 1;
  localparam int E  = 2;
  localparam int W  = 3;
  localparam int L  = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [4:0]    in_valid;
  logic [5*FW-1:0] in_flit;
  logic [4:0]    in_vc;
  logic [9:0]    credit_out;
  logic [4:0]    out_valid;
  logic [5*FW-1:0] out_flit;
  logic [4:0]    out_vc;
  logic [9:0]    credit_in;
  logic          err_overflow;

  int   errors = 0;
  int   checks = 0;
  logic auto_credit;
  int   cnt;
  int   nrec;
  int   rec [16];
  int   exp_seq [9];
  logic w_popped;

  vc_credit_router #(
    .ROUTER_ID(5), .ROUTER_COLS(4), .FLIT_W(FW), .NUM_VCS(NV),
    .BUFFER_DEPTH(4), .COORD_W(3)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_flit      (in_flit),
    .in_vc        (in_vc),
    .credit_out   (credit_out),
    .out_valid    (out_valid),
    .out_flit     (out_flit),
    .out_vc       (out_vc),
    .credit_in    (credit_in),
    .err_overflow (err_overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] mk(input bit hd, input bit tl, input bit pr,
                                     input int row, input int col, input int pay);
    logic [63:0] f;
    f        = '0;
    f[63]    = hd;
    f[62]    = tl;
    f[61]    = pr;
    f[60:58] = 3'(row);
    f[57:55] = 3'(col);
    f[15:0]  = 16'(pay);
    return f;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge, sample #1 later; a consuming downstream returns one credit per flit seen.
  task automatic step();
    @(posedge clk);
    #1;
    credit_in = '0;
    if (auto_credit)
      for (int p = 0; p < 5; p++)
        if (out_valid[p]) credit_in[p*NV + int'(out_vc[p])] = 1'b1;
  endtask

  task automatic drive(input int p, input int vc, input logic [63:0] f);
    in_valid[p]        = 1'b1;
    in_flit[p*FW +: FW] = f;
    in_vc[p]           = vc[0];
  endtask

  task automatic do_reset();
    in_valid  = '0;
    credit_in = '0;
    rst_n     = 1'b0;
    step();
    rst_n     = 1'b1;
  endtask

  function automatic logic [15:0] pay_at(input int p);
    return out_flit[p*FW +: 16];
  endfunction

  initial begin
    auto_credit = 1'b0;
    in_valid    = '0;
    in_flit     = '0;
    in_vc       = '0;
    credit_in   = '0;
    rst_n       = 1'b0;
    step();
    step();
    rst_n = 1'b1;

    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_credit_out", 64'(credit_out), 64'd0);
    check("rst_out_flit_any", 64'(|out_flit), 64'd0);
    check("rst_err", 64'(err_overflow), 64'd0);

    // Single flit from LOCAL to {1,3} exits EAST two edges later.
    drive(L, 0, mk(1, 1, 0, 1, 3, 'h17));
    step();
    in_valid = '0;
    check("t1_not_yet", 64'(out_valid), 64'd0);
    step();
    check("t1_out_valid", 64'(out_valid), 64'b00100);
    check("t1_out_flit", out_flit[E*FW +: FW], mk(1, 1, 0, 1, 3, 'h17));
    check("t1_out_vc", 64'(out_vc[E]), 64'd0);
    check("t1_credit_out", 64'(credit_out), 64'h100);
    step();
    check("t1_idle_valid", 64'(out_valid), 64'd0);
    check("t1_idle_credit", 64'(credit_out), 64'd0);

    // 3-flit N->S packet holds S VC0; W single flit waits for the tail.
    do_reset();
    auto_credit = 1'b1;
    drive(N, 0, mk(1, 0, 0, 2, 1, 'h1));
    drive(W, 0, mk(1, 1, 0, 2, 1, 'h9));
    step();
    in_valid = '0;
    drive(N, 0, mk(0, 0, 0, 0, 0, 'h2));
    step();
    check("t2_head", 64'(out_valid[S] ? pay_at(S) : 16'hffff), 64'h1);
    drive(N, 0, mk(0, 1, 0, 0, 0, 'h3));
    step();
    in_valid = '0;
    check("t2_body", 64'(out_valid[S] ? pay_at(S) : 16'hffff), 64'h2);
    step();
    check("t2_tail", 64'(out_valid[S] ? pay_at(S) : 16'hffff), 64'h3);
    step();
    check("t2_west", 64'(out_valid[S] ? pay_at(S) : 16'hffff), 64'h9);
    step();
    check("t2_drained", 64'(out_valid), 64'd0);

    // No returned credits: only BUFFER_DEPTH flits leave on E VC1.
    do_reset();
    auto_credit = 1'b0;
    cnt = 0;
    for (int k = 1; k <= 5; k++) begin
      drive(L, 1, mk(1, 1, 0, 1, 3, k));
      step();
      if (out_valid[E]) cnt++;
    end
    in_valid = '0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (out_valid[E]) cnt++;
    end
    check("t3_count", 64'(cnt), 64'd4);
    check("t3_no_err", 64'(err_overflow), 64'd0);
    credit_in[E*NV + 1] = 1'b1;
    step();
    check("t3_pulse_edge", 64'(out_valid[E]), 64'd0);
    step();
    check("t3_fifth_valid", 64'(out_valid[E]), 64'd1);
    check("t3_fifth_pay", 64'(pay_at(E)), 64'd5);
    check("t3_fifth_vc", 64'(out_vc[E]), 64'd1);

    // N, W, L contend for S; W flits carry the priority bit.
    do_reset();
    auto_credit = 1'b1;
    nrec = 0;
    for (int c = 0; c < 14; c++) begin
      if (c < 3) begin
        drive(N, 0, mk(1, 1, 0, 2, 1, N));
        drive(W, 0, mk(1, 1, 1, 2, 1, W));
        drive(L, 0, mk(1, 1, 0, 2, 1, L));
      end else begin
        in_valid = '0;
      end
      step();
      if (out_valid[S] && nrec < 16) begin
        rec[nrec] = int'(pay_at(S));
        nrec++;
      end
    end
`ifdef ROUTER_PRIORITY_EN
    exp_seq = '{W, W, W, L, N, L, N, L, N};
`else
    exp_seq = '{N, W, L, N, W, L, N, W, L};
`endif
    check("t4_count", 64'(nrec), 64'd9);
    for (int j = 0; j < 9; j++)
      check($sformatf("t4_grant%0d", j), 64'(rec[j]), 64'(exp_seq[j]));

    // Lock S VC0 with an open packet, overflow W's FIFO, then reset mid-packet.
    do_reset();
    auto_credit = 1'b0;
    drive(N, 0, mk(1, 0, 0, 2, 1, 'hA));
    step();
    in_valid = '0;
    step();
    check("t5_lock_head", 64'(out_valid[S]), 64'd1);
    for (int k = 1; k <= 5; k++) begin
      drive(W, 0, mk(1, 1, 0, 2, 1, k));
      step();
      if (k == 4) check("t5_err_before", 64'(err_overflow), 64'd0);
    end
    in_valid = '0;
    check("t5_err_after", 64'(err_overflow), 64'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("t5_rst_valid", 64'(out_valid), 64'd0);
    check("t5_rst_flit_any", 64'(|out_flit), 64'd0);
    check("t5_rst_vc", 64'(out_vc), 64'd0);
    check("t5_rst_credit_out", 64'(credit_out), 64'd0);
    check("t5_rst_err", 64'(err_overflow), 64'd0);
    cnt = 0;
    w_popped = 1'b0;
    for (int k = 0; k < 9; k++) begin
      if (k < 5) drive(L, 0, mk(1, 1, 0, 2, 1, 'h40 + k));
      else in_valid = '0;
      step();
      if (out_valid[S]) cnt++;
      if (credit_out[W*NV]) w_popped = 1'b1;
    end
    check("t5_credits_restored", 64'(cnt), 64'd4);
    check("t5_w_fifo_flushed", 64'(w_popped), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vc_credit_router.md
VC_CREDIT_ROUTER -- requirements
Module: vc_credit_router

Interface
REQ-001 Parameters, one per line: name, default, meaning:
- ROUTER_ID, 0, linear router index; row = ROUTER_ID / ROUTER_COLS, col = ROUTER_ID % ROUTER_COLS
- ROUTER_COLS, 4, mesh columns used by XY routing
- FLIT_W, 64, flit width in bits
- NUM_VCS, 2, virtual channels per port (>=1)
- BUFFER_DEPTH, 4, flits per input-VC FIFO (>=2)
- COORD_W, 3, bits per row/col coordinate
REQ-002 Ports, one per line: name, direction, width, meaning (P = 5, port order N,S,E,W,L):
- clk, in, 1, single clock
- rst_n, in, 1, reset; synchronous, active-low
- in_valid, in, P, flit present on input port p
- in_flit, in, P*FLIT_W, input flits
- in_vc, in, P*clog2(NUM_VCS), input VC id
- credit_out, out, P*NUM_VCS, one-cycle pulse: one slot freed in input FIFO (p,v)
- out_valid, out, P, flit driven on output port p
- out_flit, out, P*FLIT_W, output flits
- out_vc, out, P*clog2(NUM_VCS), output VC id (equals input VC)
- credit_in, in, P*NUM_VCS, downstream slot freed on output (p,v)
- err_overflow, out, 1, sticky: flit arrived at a full FIFO
REQ-003 Flit fields: [FLIT_W-1] head, [FLIT_W-2] tail, [FLIT_W-3] priority, next 2*COORD_W bits dest {row,col}; head=tail=1 is a single-flit packet.

Function
REQ-004 Each (input, VC) has its own FIFO of BUFFER_DEPTH; write on in_valid when not full; a write to a full FIFO drops the flit and sets err_overflow.
REQ-005 Route of a head flit: dest col > col -> E; < col -> W; else dest row > row -> S; < row -> N; else L; the route is stored per (input, VC) and reused by body/tail flits.
REQ-006 Per output VC a credit counter, reset to BUFFER_DEPTH; decrement on flit sent, increment on credit_in; both in one cycle -> unchanged; never exceeds BUFFER_DEPTH or drops below 0.
REQ-007 An (input, VC) is ready when its FIFO is non-empty, the target output VC has credit > 0, and either the flit is a head and the output VC is unlocked, or the output VC is locked to this (input, VC).
REQ-008 Stage 1: each input picks one ready VC round-robin; Stage 2: each output picks one requesting input round-robin; pointers advance to one past the winner only on grant.
REQ-009 A granted head flit locks the output VC to (input, VC); a granted tail flit releases it the same edge; a head+tail flit locks nothing.
REQ-010 Latency: a flit written at edge t is eligible in cycle t+1 and, if granted, appears on out_valid/out_flit/out_vc registered after edge t+1; zero-load latency is 2 cycles.
REQ-011 credit_out(p,v) pulses in the same cycle the popped flit's out_valid is high; at most one pop per input per cycle, at most one flit per output per cycle.
REQ-012 Flits of a packet leave in order with no interleaving of other packets on the same output VC.

Reset
REQ-013 With rst_n low at a clock edge: FIFOs empty, locks cleared, RR pointers 0, credits = BUFFER_DEPTH, out_valid = 0, out_flit = 0, out_vc = 0, credit_out = 0, err_overflow = 0; in-flight packets are discarded.

Configuration
REQ-014 ROUTER_PRIORITY_EN defined: in both stages, ready candidates with priority=1 head flits (or locked body of a priority packet) beat priority=0; RR among equals. Undefined: priority bit ignored, pure RR.

Structure
REQ-015 Package router_pkg holds the port enum (NORTH=0, SOUTH, EAST, WEST, LOCAL), NUM_PORTS=5, flit field offset constants and the xy_route function.
REQ-016 One sub-module vc_fifo (parameterised width/depth, push/pop/full/empty), instantiated P*NUM_VCS times.

Verification
REQ-017 ROUTER_ID=5, COLS=4: single-flit on L, dest {1,3} -> out_valid on E two cycles later; credit_out(L,v0) pulses same cycle.
REQ-018 3-flit packet N->S on VC0 while single-flit W->S on VC0 -> W flit waits until N tail sent; no interleave.
REQ-019 credit_in held 0, send 5 flits to E VC1 with depth 4 -> exactly 4 forwarded; 5th sent one cycle after a credit_in pulse.
REQ-020 N, W, L all single-flit to S every cycle -> grants rotate N,W,L,N...; with ROUTER_PRIORITY_EN and W priority=1 -> W wins every cycle.
REQ-021 Write 5 flits to one FIFO with output blocked -> err_overflow=1 after 5th; rst_n low for 1 edge mid-packet -> all outputs 0, credits 4, err_overflow 0.
